// File: rtl/systolic_tile_sequencer.sv
// Job controller for one systolic tile: loads A/B queues,
// starts them, collects channel completion, drains, reports done.
module systolic_tile_sequencer #(
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 2*N+2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  output logic                  row_wr_en_o,
  output logic                  col_wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_reset_o,
  output logic                  start_o,
  input  logic [N-1:0]          row_last_i,
  input  logic [N-1:0]          col_last_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  localparam int WORDS = N*N;
  localparam int LCW   = $clog2(WORDS+1);
  localparam int DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [LCW-1:0] LAST_WORD  = LCW'(WORDS-1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES-1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_START  = 3'd4,
    S_RUN    = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t         r_state;
  logic [LCW-1:0] r_load_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic [N-1:0]   r_row_mask;
  logic [N-1:0]   r_col_mask;

  logic w_in_load;
  logic w_accept;
  logic w_last_word;
  logic w_masks_full;
  logic w_collect;

  assign w_in_load    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_accept     = load_valid_i && w_in_load;
  assign w_last_word  = r_load_cnt == LAST_WORD;
  assign w_masks_full = (&r_row_mask) && (&r_col_mask);
  // Last pulses only count once the queues have been started.
  assign w_collect    = (r_state == S_START) || (r_state == S_RUN) ||
                        (r_state == S_DRAIN) || (r_state == S_DONE);

  // Job sequencing, load/drain counting and sticky last masks.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_load_cnt  <= '0;
      r_drain_cnt <= '0;
      r_row_mask  <= '0;
      r_col_mask  <= '0;
    end else begin
      if (w_collect) begin
        r_row_mask <= r_row_mask | row_last_i;
        r_col_mask <= r_col_mask | col_last_i;
      end
      unique case (r_state)
        S_IDLE: begin
          if (job_valid_i) r_state <= S_CLR;
        end
        S_CLR: begin
          r_load_cnt <= '0;
          r_row_mask <= '0;
          r_col_mask <= '0;
          r_state    <= S_LOAD_A;
        end
        S_LOAD_A: begin
          if (w_accept) begin
            if (w_last_word) begin
              r_load_cnt <= '0;
              r_state    <= S_LOAD_B;
            end else begin
              r_load_cnt <= r_load_cnt + LCW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (w_accept) begin
            if (w_last_word) begin
              r_load_cnt <= '0;
              r_state    <= S_START;
            end else begin
              r_load_cnt <= r_load_cnt + LCW'(1);
            end
          end
        end
        S_START: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_masks_full) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready_o  = r_state == S_IDLE;
  assign load_ready_o = w_in_load;
  assign row_wr_en_o  = load_valid_i && (r_state == S_LOAD_A);
  assign col_wr_en_o  = load_valid_i && (r_state == S_LOAD_B);
  assign wr_data_o    = load_data_i;
  assign wr_reset_o   = r_state == S_CLR;
  assign start_o      = r_state == S_START;
  assign busy_o       = r_state != S_IDLE;
  assign done_o       = r_state == S_DONE;
  assign state_o      = r_state;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: vector table for reset/entry,
// then scripted and randomized jobs against a queue/mask model.
module tb_systolic_tile_sequencer;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DR = 10;
  localparam int WORDS = N*N;

  logic          clk;
  logic          rstn_i;
  logic          job_valid_i;
  logic          job_ready_o;
  logic          load_valid_i;
  logic [DW-1:0] load_data_i;
  logic          load_ready_o;
  logic          row_wr_en_o;
  logic          col_wr_en_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_reset_o;
  logic          start_o;
  logic [N-1:0]  row_last_i;
  logic [N-1:0]  col_last_i;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    state_o;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] row_q[$];
  logic [DW-1:0] col_q[$];

  systolic_tile_sequencer #(
    .N(N), .DATA_WIDTH(DW), .DRAIN_CYCLES(DR)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o),
    .row_wr_en_o(row_wr_en_o), .col_wr_en_o(col_wr_en_o),
    .wr_data_o(wr_data_o), .wr_reset_o(wr_reset_o),
    .start_o(start_o),
    .row_last_i(row_last_i), .col_last_i(col_last_i),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect queue writes as the queues would see them.
  always @(negedge clk) begin
    if (rstn_i) begin
      if (row_wr_en_o) row_q.push_back(wr_data_o);
      if (col_wr_en_o) col_q.push_back(wr_data_o);
      chk("we_exclusive", 32'(row_wr_en_o && col_wr_en_o), 0);
    end
  end

  // obs = {state, ready, load_ready, row_we, col_we, wr_reset, start, done, busy}
  typedef struct {
    logic        rst;
    logic        jv;
    logic        lv;
    logic [31:0] d;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic check_queues(input logic [31:0] base);
    chk("row_count", row_q.size(), WORDS);
    chk("col_count", col_q.size(), WORDS);
    for (int i = 0; i < row_q.size(); i++)
      chk("row_data", row_q[i], base + 32'(i));
    for (int i = 0; i < col_q.size(); i++)
      chk("col_data", col_q[i], base + 32'(WORDS + i));
    row_q.delete();
    col_q.delete();
  endtask

  task automatic do_job(input bit rnd, input bit hold_end,
                        input logic [31:0] base);
    int idx;
    int guard;
    int quiet;
    int k;
    logic [N-1:0] mr;
    logic [N-1:0] mc;
    logic [N-1:0] pr;
    logic [N-1:0] pc;
    chk("idle_ready", 32'(job_ready_o), 1);
    job_valid_i = 1'b1;
    tick();
    row_last_i = '1;
    col_last_i = '1;
    #1;
    chk("clr_state", 32'(state_o), 1);
    chk("clr_wr_reset", 32'(wr_reset_o), 1);
    chk("clr_ready", 32'(job_ready_o), 0);
    tick();
    row_last_i  = '0;
    col_last_i  = '0;
    job_valid_i = hold_end;
    idx = 0;
    guard = 0;
    while (idx < 2*WORDS && guard < 2000) begin
      load_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data_i  = base + 32'(idx);
      #1;
      chk("load_state", 32'(state_o), (idx < WORDS) ? 2 : 3);
      chk("load_ready", 32'(load_ready_o), 1);
      chk("row_we", 32'(row_wr_en_o), 32'(load_valid_i && idx < WORDS));
      chk("col_we", 32'(col_wr_en_o), 32'(load_valid_i && idx >= WORDS));
      if (load_valid_i) idx++;
      guard++;
      tick();
    end
    if (idx < 2*WORDS) begin
      n_vec++;
      n_bad++;
      $display("FAIL load_timeout: got %0d words expected %0d", idx, 2*WORDS);
    end
    load_valid_i = 1'b1;
    load_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("start_state", 32'(state_o), 4);
    chk("start_pulse", 32'(start_o), 1);
    chk("start_no_we", 32'(row_wr_en_o | col_wr_en_o), 0);
    check_queues(base);
    tick();
    load_valid_i = 1'b0;
    quiet = rnd ? int'($urandom_range(1, 3)) : 0;
    mr = '0;
    mc = '0;
    guard = 0;
    while (!((&mr) && (&mc)) && guard < 200) begin
      pr = '0;
      pc = '0;
      if (guard >= quiet) begin
        if (!rnd) begin
          k = guard - quiet;
          if (k == 0) pc = '1;
          else pr = N'(1 << (k - 1));
        end else begin
          pr = N'($urandom & $urandom);
          pc = N'($urandom & $urandom);
        end
      end
      row_last_i = pr;
      col_last_i = pc;
      #1;
      chk("run_state", 32'(state_o), 5);
      chk("run_busy", 32'(busy_o), 1);
      mr |= pr;
      mc |= pc;
      guard++;
      tick();
    end
    if (!((&mr) && (&mc))) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_timeout: got masks %0h/%0h expected all ones", mr, mc);
    end
    row_last_i = '0;
    col_last_i = '0;
    #1;
    chk("run_settle", 32'(state_o), 5);
    tick();
    for (int c = 0; c < DR; c++) begin
      row_last_i = N'($urandom);
      col_last_i = N'($urandom);
      #1;
      chk("drain_state", 32'(state_o), 6);
      chk("drain_done", 32'(done_o), 0);
      tick();
    end
    row_last_i = hold_end ? '1 : '0;
    col_last_i = hold_end ? '1 : '0;
    #1;
    chk("done_state", 32'(state_o), 7);
    chk("done_pulse", 32'(done_o), 1);
    tick();
    job_valid_i = hold_end;
    #1;
    chk("post_state", 32'(state_o), 0);
    chk("post_done", 32'(done_o), 0);
    chk("post_ready", 32'(job_ready_o), 1);
    chk("post_busy", 32'(busy_o), 0);
  endtask

  task automatic reset_in_load_b();
    job_valid_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
    tick();
    for (int i = 0; i < WORDS + 5; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = 32'h7000 + 32'(i);
      tick();
    end
    load_valid_i = 1'b1;
    #1;
    chk("pre_rst_state", 32'(state_o), 3);
    chk("pre_rst_colq", col_q.size(), 5);
    rstn_i = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_col_we", 32'(col_wr_en_o), 0);
    chk("rst_ready", 32'(job_ready_o), 1);
    tick();
    rstn_i = 1'b1;
    load_valid_i = 1'b0;
    row_q.delete();
    col_q.delete();
    #1;
    chk("rst_release", 32'(state_o), 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0AA, 11'b000_10000000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h000, 11'b000_10000000};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h011, 11'b000_10000000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h022, 11'b001_00001001};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h033, 11'b010_01100001};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h044, 11'b010_01000001};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h055, 11'b010_01100001};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h066, 11'b000_10000000};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h077, 11'b000_10000000};

    rstn_i       = 1'b0;
    job_valid_i  = 1'b0;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    row_last_i   = '0;
    col_last_i   = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      rstn_i       = tbl[i].rst;
      job_valid_i  = tbl[i].jv;
      load_valid_i = tbl[i].lv;
      load_data_i  = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_outs", i),
          32'({state_o, job_ready_o, load_ready_o, row_wr_en_o,
               col_wr_en_o, wr_reset_o, start_o, done_o, busy_o}),
          32'(tbl[i].exp));
      chk($sformatf("vec%0d_data", i), wr_data_o, tbl[i].d);
      tick();
    end
    job_valid_i  = 1'b0;
    load_valid_i = 1'b0;
    row_q.delete();
    col_q.delete();

    do_job(1'b0, 1'b0, 32'h0);
    for (int j = 0; j < 3; j++)
      do_job(1'b1, 1'b0, $urandom);
    reset_in_load_b();
    do_job(1'b1, 1'b0, 32'h4000);
    do_job(1'b1, 1'b1, 32'h5000);
    do_job(1'b1, 1'b0, 32'h6000);
    tick();
    #1;
    chk("final_idle", 32'(state_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
